sram_arbiter: RTL and testbench

//  Shares the single-port 1K x 32 scratchpad SRAM (sram) among NUM_REQ datapath requesters.

---
 rtl/sram_arb_pkg.sv | 29 ++
 rtl/rr_arbiter.sv | 37 +++
 rtl/sram_arbiter.sv | 147 ++++++++++++++
 tb/tb_sram_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// Shared types and defaults for the scratchpad SRAM arbiter.
// Optional WAIT timeout is enabled by defining SRAM_ARB_TIMEOUT_EN.
package sram_arb_pkg;

  localparam int DEF_NUM_REQ     = 3;
  localparam int DEF_ADDR_W      = 10;
  localparam int DEF_DATA_W      = 32;
  localparam int DEF_TIMEOUT_CYC = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  typedef enum logic [1:0] {
    SRAM_FREE   = 2'b00,
    SRAM_BUSY   = 2'b01,
    SRAM_ACCESS = 2'b10,
    SRAM_ERROR  = 2'b11
  } sram_state_e;

  // ACCESS and ERROR both end the WAIT phase; they share the upper bit.
  function automatic logic sram_finished(input logic [1:0] st);
    return st[1];
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: one-hot grant for the first valid
// requester at or after ptr, wrapping around to index 0.
module rr_arbiter #(
  parameter int N     = 3,
  parameter int PTR_W = 2
) (
  input  logic [N-1:0]     valid,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [PTR_W-1:0] grant_idx,
  output logic             any
);

  logic [N-1:0] upper;
  logic [N-1:0] pool;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_mask
      assign upper[gi] = valid[gi] && (PTR_W'(gi) >= ptr);
    end
  endgenerate

  // Nothing at or above the pointer means the search wraps to the bottom.
  assign any  = |valid;
  assign pool = (|upper) ? upper : valid;

  always_comb begin
    grant_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (pool[i]) grant_idx = PTR_W'(i);
    end
  end

  assign grant = any ? (N'(1) << grant_idx) : '0;

endmodule

// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one single-port scratchpad SRAM among requesters.
// Define SRAM_ARB_TIMEOUT_EN to bound the WAIT phase to TIMEOUT_CYC cycles.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int NUM_REQ     = DEF_NUM_REQ,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ-1:0]               req_write,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]               rsp_valid,
  output logic [DATA_W-1:0]                rsp_rdata,
  output logic                             rsp_err,
  output logic                             busy,
  output logic [ADDR_W-1:0]                sram_addr,
  output logic                             sram_read_en,
  output logic                             sram_write_en,
  output logic [DATA_W-1:0]                sram_write_data,
  input  logic [DATA_W-1:0]                sram_read_data,
  input  logic [1:0]                       sram_state
);

  localparam int PTR_W = $clog2(NUM_REQ);

  generate
    if (NUM_REQ < 2 || TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_bad_cfg
      $error("sram_arbiter: NUM_REQ must be >= 2 and TIMEOUT_CYC in 1..255");
    end
  endgenerate

  arb_state_e           state;
  logic [PTR_W-1:0]     ptr;
  logic [PTR_W-1:0]     next_ptr;
  logic [NUM_REQ-1:0]   owner;
  logic                 op_write;

  logic [NUM_REQ-1:0]   pick_onehot;
  logic [PTR_W-1:0]     pick_idx;
  logic                 pick_any;

  logic                 access_ok;
  logic                 finished;
  logic                 timeout;

  rr_arbiter #(
    .N     (NUM_REQ),
    .PTR_W (PTR_W)
  ) u_rr (
    .valid     (req_valid),
    .ptr       (ptr),
    .grant     (pick_onehot),
    .grant_idx (pick_idx),
    .any       (pick_any)
  );

  assign next_ptr  = (pick_idx == PTR_W'(NUM_REQ - 1)) ? '0 : pick_idx + PTR_W'(1);
  assign access_ok = (sram_state == SRAM_ACCESS);
  assign finished  = sram_finished(sram_state) || timeout;

`ifdef SRAM_ARB_TIMEOUT_EN
  logic [7:0] wait_cnt;

  // Counts completed WAIT cycles; the limit fires on the last allowed one.
  assign timeout = (state == WAIT) && (wait_cnt == 8'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (state == ISSUE) begin
      wait_cnt <= '0;
    end else if (state == WAIT) begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // Outputs are registered against the state being entered, so the SRAM
  // strobes are already up during the ISSUE cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      ptr             <= '0;
      owner           <= '0;
      op_write        <= 1'b0;
      req_ready       <= '0;
      rsp_valid       <= '0;
      rsp_rdata       <= '0;
      rsp_err         <= 1'b0;
      busy            <= 1'b0;
      sram_addr       <= '0;
      sram_read_en    <= 1'b0;
      sram_write_en   <= 1'b0;
      sram_write_data <= '0;
    end else begin
      req_ready <= '0;
      rsp_valid <= '0;
      case (state)
        IDLE: begin
          if (pick_any) begin
            state           <= ISSUE;
            busy            <= 1'b1;
            ptr             <= next_ptr;
            owner           <= pick_onehot;
            req_ready       <= pick_onehot;
            op_write        <= req_write[pick_idx];
            sram_addr       <= req_addr[pick_idx];
            sram_write_data <= req_wdata[pick_idx];
            sram_write_en   <= req_write[pick_idx];
            sram_read_en    <= !req_write[pick_idx];
          end
        end
        ISSUE: begin
          state <= WAIT;
        end
        WAIT: begin
          if (finished) begin
            state         <= RESP;
            sram_read_en  <= 1'b0;
            sram_write_en <= 1'b0;
            rsp_valid     <= owner;
            rsp_err       <= !access_ok;
            rsp_rdata     <= (access_ok && !op_write) ? sram_read_data : '0;
          end
        end
        RESP: begin
          state     <= IDLE;
          busy      <= 1'b0;
          rsp_rdata <= '0;
          rsp_err   <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: directed scenarios plus randomized traffic
// checked every cycle against a transaction-level model and a behavioural SRAM.
module tb_sram_arbiter;

  localparam int N  = 3;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int TO = 16;
`ifdef SRAM_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst;
  logic [N-1:0]        req_valid, req_ready, req_write, rsp_valid;
  logic [N-1:0][AW-1:0] req_addr;
  logic [N-1:0][DW-1:0] req_wdata;
  logic [DW-1:0]       rsp_rdata, sram_write_data, sram_read_data;
  logic                rsp_err, busy, sram_read_en, sram_write_en;
  logic [AW-1:0]       sram_addr;
  logic [1:0]          sram_state;

  always #5 clk = ~clk;

  sram_arbiter dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
    .sram_addr(sram_addr), .sram_read_en(sram_read_en), .sram_write_en(sram_write_en),
    .sram_write_data(sram_write_data), .sram_read_data(sram_read_data),
    .sram_state(sram_state)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @%0t: got %h, expected %h", nm, $time, act, exp);
    end
  endtask

  // ---------------- behavioural SRAM device ----------------
  logic [DW-1:0] dev_mem [0:1023];
  int dev_cnt;
  int dev_lat   = 3;
  bit dev_err   = 1'b0;
  bit dev_stuck = 1'b0;

  assign sram_read_data = dev_mem[sram_addr];

  always_comb begin
    sram_state = 2'b00;
    if (sram_read_en || sram_write_en) begin
      if (dev_stuck || dev_cnt < dev_lat) sram_state = 2'b01;
      else sram_state = dev_err ? 2'b11 : 2'b10;
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      dev_cnt <= 0;
      for (int a = 0; a < 1024; a++) dev_mem[a] <= '0;
    end else if (sram_read_en || sram_write_en) begin
      if (sram_state == 2'b10 && sram_write_en) dev_mem[sram_addr] <= sram_write_data;
      dev_cnt <= sram_state[1] ? 0 : dev_cnt + 1;
    end else begin
      dev_cnt <= 0;
    end
  end

  // ---------------- transaction-level reference model ----------------
  function automatic int pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return 0;
  endfunction

  int            cand;
  logic [DW-1:0] ref_mem [0:1023];
  bit            m_active, m_first, m_resp, m_write;
  int            m_g, m_ptr, m_wait;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [N-1:0]  exp_ready, exp_rsp;
  logic [DW-1:0] exp_rdata;
  logic          exp_err, exp_busy, exp_rd, exp_wr;

  always_comb cand = pick(req_valid, m_ptr);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active <= 0; m_first <= 0; m_resp <= 0; m_ptr <= 0; m_wait <= 0;
      exp_ready <= '0; exp_rsp <= '0; exp_rdata <= '0; exp_err <= 0;
      exp_busy <= 0; exp_rd <= 0; exp_wr <= 0;
      for (int a = 0; a < 1024; a++) ref_mem[a] <= '0;
    end else if (m_resp) begin
      m_resp <= 0; m_active <= 0; exp_rsp <= '0; exp_rdata <= '0; exp_err <= 0; exp_busy <= 0;
    end else if (!m_active) begin
      if (req_valid != '0) begin
        m_active  <= 1; m_first <= 1; m_g <= cand; m_ptr <= (cand + 1) % N;
        m_write   <= req_write[cand];
        m_addr    <= req_addr[cand];
        m_wdata   <= req_wdata[cand];
        exp_ready <= N'(1) << cand;
        exp_wr    <= req_write[cand];
        exp_rd    <= !req_write[cand];
        exp_busy  <= 1;
      end
    end else if (m_first) begin
      m_first <= 0; exp_ready <= '0; m_wait <= 0;
    end else begin
      m_wait <= m_wait + 1;
      if (sram_state[1] || (TO_EN && m_wait + 1 >= TO)) begin
        m_resp    <= 1;
        exp_rsp   <= N'(1) << m_g;
        exp_rd    <= 0;
        exp_wr    <= 0;
        exp_err   <= (sram_state != 2'b10);
        exp_rdata <= (sram_state == 2'b10 && !m_write) ? ref_mem[m_addr] : '0;
        if (sram_state == 2'b10 && m_write) ref_mem[m_addr] <= m_wdata;
      end
    end
  end

  // ---------------- per-cycle comparison and event counters ----------------
  int wen_cnt, ren_cnt, both_cnt, rsp_cnt;

  always @(negedge clk) begin
    chk("req_ready", 32'(req_ready), 32'(exp_ready));
    chk("rsp_valid", 32'(rsp_valid), 32'(exp_rsp));
    chk("busy", 32'(busy), 32'(exp_busy));
    chk("sram_read_en", 32'(sram_read_en), 32'(exp_rd));
    chk("sram_write_en", 32'(sram_write_en), 32'(exp_wr));
    if (exp_rsp != '0) begin
      chk("rsp_rdata", rsp_rdata, exp_rdata);
      chk("rsp_err", 32'(rsp_err), 32'(exp_err));
    end
    if (exp_rd || exp_wr) chk("sram_addr", 32'(sram_addr), 32'(m_addr));
    if (exp_wr) chk("sram_write_data", sram_write_data, m_wdata);
    if (sram_write_en) wen_cnt++;
    if (sram_read_en) ren_cnt++;
    if (sram_write_en && sram_read_en) both_cnt++;
    if (rsp_valid != '0) rsp_cnt++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic issue(input int i, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i] = 1'b1;
    req_write[i] = w;
    req_addr[i]  = a;
    req_wdata[i] = d;
  endtask

  task automatic run_until_rsp(input int budget, output logic [N-1:0] v,
                               output logic e, output logic [DW-1:0] d);
    v = '0; e = 1'b0; d = '0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (req_ready != '0) req_valid = req_valid & ~req_ready;
      if (rsp_valid != '0) begin
        v = rsp_valid; e = rsp_err; d = rsp_rdata;
        return;
      end
    end
    tests++; fails++;
    $display("FAIL rsp_wait_budget @%0t: got no response, expected one within %0d cycles", $time, budget);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req_valid = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  logic [N-1:0]  rv;
  logic          re;
  logic [DW-1:0] rd;
  logic [N-1:0]  order [6];
  logic [N-1:0]  order_exp [6];

  initial begin
    rst = 1'b1; req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    wen_cnt = 0; ren_cnt = 0; both_cnt = 0; rsp_cnt = 0;

    // 1: reset values
    repeat (2) @(negedge clk);
    chk("t1_busy_in_rst", 32'(busy), 32'd0);
    chk("t1_ready_in_rst", 32'(req_ready), 32'd0);
    chk("t1_en_in_rst", 32'({sram_read_en, sram_write_en}), 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("t1_busy_after", 32'(busy), 32'd0);
    chk("t1_rsp_after", 32'(rsp_valid), 32'd0);

    // 2: write from requester 0, SRAM takes 5 cycles
    dev_lat = 5; wen_cnt = 0;
    issue(0, 1'b1, 10'd300, 32'hFFFF_FFFF);
    run_until_rsp(100, rv, re, rd);
    chk("t2_wen_cycles", 32'(wen_cnt), 32'd6);
    chk("t2_rsp_valid", 32'(rv), 32'b001);
    chk("t2_rsp_err", 32'(re), 32'd0);

    // 3: read back from requester 1
    dev_lat = 2; wen_cnt = 0; ren_cnt = 0;
    @(negedge clk);
    issue(1, 1'b0, 10'd300, 32'd0);
    run_until_rsp(100, rv, re, rd);
    chk("t3_rsp_valid", 32'(rv), 32'b010);
    chk("t3_rdata", rd, 32'hFFFF_FFFF);
    chk("t3_no_write_en", 32'(wen_cnt), 32'd0);
    chk("t3_read_en_cycles", 32'(ren_cnt), 32'd3);

    // 4: three persistent requesters from a fresh pointer
    do_reset();
    dev_lat = 1; both_cnt = 0;
    order_exp = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    for (int i = 0; i < N; i++) issue(i, 1'b0, AW'(i + 1), 32'd0);
    begin
      int n = 0;
      for (int c = 0; c < 200 && n < 6; c++) begin
        @(negedge clk);
        if (req_ready != '0) begin
          order[n] = req_ready;
          n++;
        end
      end
      req_valid = '0;
      chk("t4_grant_count", 32'(n), 32'd6);
      for (int i = 0; i < 6; i++) chk($sformatf("t4_order%0d", i), 32'(order[i]), 32'(order_exp[i]));
    end
    repeat (8) @(negedge clk);
    chk("t4_both_enables", 32'(both_cnt), 32'd0);

    // 5: SRAM error during WAIT
    dev_lat = 2; dev_err = 1'b1;
    issue(2, 1'b0, 10'd5, 32'd0);
    run_until_rsp(100, rv, re, rd);
    chk("t5_rsp_valid", 32'(rv), 32'b100);
    chk("t5_rsp_err", 32'(re), 32'd1);
    chk("t5_rdata", rd, 32'd0);
    chk("t5_en_dropped", 32'({sram_read_en, sram_write_en}), 32'd0);
    @(negedge clk);
    chk("t5_idle", 32'(busy), 32'd0);
    dev_err = 1'b0;

    // 6: SRAM stuck busy
    dev_stuck = 1'b1; ren_cnt = 0;
    issue(0, 1'b0, 10'd7, 32'd0);
`ifdef SRAM_ARB_TIMEOUT_EN
    run_until_rsp(60, rv, re, rd);
    chk("t6_to_rsp_valid", 32'(rv), 32'b001);
    chk("t6_to_err", 32'(re), 32'd1);
    chk("t6_to_rdata", rd, 32'd0);
    chk("t6_to_en_cycles", 32'(ren_cnt), 32'd17);
    @(negedge clk);
    issue(0, 1'b0, 10'd7, 32'd0);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (req_ready != '0) req_valid = req_valid & ~req_ready;
    end
`else
    rsp_cnt = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (req_ready != '0) req_valid = req_valid & ~req_ready;
    end
    chk("t6_still_busy", 32'(busy), 32'd1);
    chk("t6_still_enabled", 32'(sram_read_en), 32'd1);
    chk("t6_no_rsp", 32'(rsp_cnt), 32'd0);
`endif
    #2 rst = 1'b1;
    #1;
    chk("t6_async_en", 32'({sram_read_en, sram_write_en}), 32'd0);
    chk("t6_async_busy", 32'(busy), 32'd0);
    dev_stuck = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rsp_cnt = 0;
    repeat (10) @(negedge clk);
    chk("t6_lost_txn", 32'(rsp_cnt), 32'd0);

    // randomized traffic
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (req_ready[i]) begin
          dev_lat = $urandom_range(1, 6);
          dev_err = ($urandom % 8 == 0);
          req_valid[i] = 1'b0;
          if ($urandom % 3 != 0)
            issue(i, 1'($urandom % 2), AW'($urandom % 16), $urandom);
        end else if (!req_valid[i]) begin
          if ($urandom % 4 == 0)
            issue(i, 1'($urandom % 2), AW'($urandom % 16), $urandom);
        end else if ($urandom % 20 == 0) begin
          req_valid[i] = 1'b0;
        end
      end
    end
    req_valid = '0;
    begin
      int c = 0;
      while (busy && c < 100) begin
        @(negedge clk);
        c++;
      end
      chk("final_idle", 32'(busy), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
